// File: rtl/fetch_pc_stage.sv
// fetch_pc_stage
//   Fetch-stage program counter and IF/ID pipeline register.
//   The EX stage supplies the PC of a resolved branch/jump and its offset. The offset
//   has already been word-scaled by the shift-left-by-2 stage. Their sum is the
//   redirect target. Each cycle the next fetch PC is picked from three choices:
//   redirect, hold (stall) or sequential +4. The instruction returned by imem for
//   pc_f is captured into decode under stall/flush control.
//
// Parameters
//   RESET_PC   pc_f value loaded on reset
//   NOP_INSTR  instr_d value on reset/flush (addi x0,x0,0)
//   CNT_W      width of the redirect performance counter
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous active-high reset
//   stall_f       in   hold pc_f
//   stall_d       in   hold IF/ID register
//   flush_d       in   squash IF/ID register
//   pc_src_e      in   taken branch/jump in EX, redirect fetch
//   pc_e          in   PC of the branch in EX
//   branch_off_e  in   word-scaled branch offset
//   instr_f       in   imem read data for pc_f
//   pc_f          out  imem fetch address
//   instr_d       out  instruction in decode
//   pc_d          out  PC of instr_d
//   pc_plus4_d    out  pc_d + 4
//   valid_d       out  instr_d is a real instruction
//   redirect_cnt  out  number of redirect cycles (wrapping)
module fetch_pc_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_f,
  input  logic             stall_d,
  input  logic             flush_d,
  input  logic             pc_src_e,
  input  logic [31:0]      pc_e,
  input  logic [31:0]      branch_off_e,
  input  logic [31:0]      instr_f,
  output logic [31:0]      pc_f,
  output logic [31:0]      instr_d,
  output logic [31:0]      pc_d,
  output logic [31:0]      pc_plus4_d,
  output logic             valid_d,
  output logic [CNT_W-1:0] redirect_cnt
);

  logic [31:0]      r_pc_f;
  logic [31:0]      r_instr_d;
  logic [31:0]      r_pc_d;
  logic [31:0]      r_pc_plus4_d;
  logic             r_valid_d;
  logic [CNT_W-1:0] r_redirect_cnt;

  logic [31:0]      w_target_sum;
  logic [31:0]      w_target_e;
  logic [31:0]      w_pc_plus4_f;

  // The target is forced word-aligned. A misaligned pc_e or offset can then
  // never put a misaligned address on imem.
  assign w_target_sum = pc_e + branch_off_e;
  assign w_target_e   = {w_target_sum[31:2], 2'b00};
  assign w_pc_plus4_f = r_pc_f + 32'd4;

  // Next-PC selection. A redirect wins over stall_f because the instruction
  // being held is on the wrong path anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_f <= RESET_PC;
    end else if (pc_src_e) begin
      r_pc_f <= w_target_e;
    end else if (!stall_f) begin
      r_pc_f <= w_pc_plus4_f;
    end
  end

  // IF/ID register. A redirect squashes the wrong-path instruction now in IF
  // just like an explicit flush. The PC fields keep their old values on a squash.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= 32'd0;
      r_pc_plus4_d <= 32'd0;
      r_valid_d    <= 1'b0;
    end else if (flush_d || pc_src_e) begin
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end else if (!stall_d) begin
      r_instr_d    <= instr_f;
      r_pc_d       <= r_pc_f;
      r_pc_plus4_d <= w_pc_plus4_f;
      r_valid_d    <= 1'b1;
    end
  end

  // Performance counter of redirect cycles. It wraps silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_redirect_cnt <= '0;
    end else if (pc_src_e) begin
      r_redirect_cnt <= r_redirect_cnt + 1'b1;
    end
  end

  assign pc_f         = r_pc_f;
  assign instr_d      = r_instr_d;
  assign pc_d         = r_pc_d;
  assign pc_plus4_d   = r_pc_plus4_d;
  assign valid_d      = r_valid_d;
  assign redirect_cnt = r_redirect_cnt;

endmodule
